// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/mtval/mstatus through the CSR
// trap channel on exceptions and interrupts, restores mstatus on mret, then redirects the PC.
module trap_ctrl #(
  parameter int          XLEN        = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MTVEC   = 12'h305,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [11:0] CSR_MTVAL   = 12'h343
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [31:0]     inst_i,
  input  logic            illegal_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            ex_trap_valid_i,
  input  logic            tcmp_trap_valid_i,
  input  logic            soft_trap_valid_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] trap_csr_rdata_i,
  output logic            trap_csr_we_o,
  output logic [11:0]     trap_csr_addr_o,
  output logic [XLEN-1:0] trap_csr_wdata_o,
  output logic            hold_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE, S_MEPC, S_MCAUSE, S_MTVAL, S_MSTATUS, S_JUMP, S_MRET, S_MRET_JUMP
  } state_t;

  localparam logic [XLEN-1:0] IRQ_BIT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [XLEN-1:0] epc_p0, cause_p0, tval_p0;
  logic [XLEN-1:0] cause_nxt, tval_nxt;
  logic            take_trap, take_mret;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [XLEN-1:0] mstatus_enter(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1.
  function automatic logic [XLEN-1:0] mstatus_leave(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause_nxt = '0;
    tval_nxt  = '0;
    if (inst_valid_i) begin
      if (illegal_i) begin
        take_trap = 1'b1;
        cause_nxt = XLEN'(2);
        tval_nxt  = XLEN'(inst_i);
      end else if (ecall_i) begin
        take_trap = 1'b1;
        cause_nxt = XLEN'(11);
      end else if (ebreak_i) begin
        take_trap = 1'b1;
        cause_nxt = XLEN'(3);
      end else if (mret_i) begin
        take_mret = 1'b1;
      end else if (mstatus_mie_i) begin
        if (ex_trap_valid_i) begin
          take_trap = 1'b1;
          cause_nxt = IRQ_BIT | XLEN'(11);
        end else if (soft_trap_valid_i) begin
          take_trap = 1'b1;
          cause_nxt = IRQ_BIT | XLEN'(3);
        end else if (tcmp_trap_valid_i) begin
          take_trap = 1'b1;
          cause_nxt = IRQ_BIT | XLEN'(7);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      epc_p0   <= '0;
      cause_p0 <= '0;
      tval_p0  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take_trap) begin
        epc_p0   <= inst_addr_i;
        cause_p0 <= cause_nxt;
        tval_p0  <= tval_nxt;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    hold_o           = 1'b0;
    jump_o           = 1'b0;
    jump_addr_o      = '0;
    case (state)
      IDLE: begin
        if (take_trap) begin
          hold_o    = 1'b1;
          state_nxt = S_MEPC;
        end else if (take_mret) begin
          hold_o    = 1'b1;
          state_nxt = S_MRET;
        end
      end
      S_MEPC: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MEPC;
        trap_csr_wdata_o = epc_p0;
        state_nxt        = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MCAUSE;
        trap_csr_wdata_o = cause_p0;
        state_nxt        = S_MTVAL;
      end
      S_MTVAL: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MTVAL;
        trap_csr_wdata_o = tval_p0;
        state_nxt        = S_MSTATUS;
      end
      S_MSTATUS: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = mstatus_enter(trap_csr_rdata_i);
        state_nxt        = S_JUMP;
      end
      S_JUMP: begin
        hold_o          = 1'b1;
        trap_csr_addr_o = CSR_MTVEC;
        jump_o          = 1'b1;
        jump_addr_o     = {trap_csr_rdata_i[XLEN-1:2], 2'b00};
        state_nxt       = IDLE;
      end
      S_MRET: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = mstatus_leave(trap_csr_rdata_i);
        state_nxt        = S_MRET_JUMP;
      end
      S_MRET_JUMP: begin
        hold_o      = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences the channel in the same cycle so no half-sequence write escapes.
    if (rst) begin
      trap_csr_we_o    = 1'b0;
      trap_csr_addr_o  = '0;
      trap_csr_wdata_o = '0;
      hold_o           = 1'b0;
      jump_o           = 1'b0;
      jump_addr_o      = '0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a small CSR file answers the trap channel while a
// transaction-level model predicts every cycle's channel/stall/redirect outputs.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst_addr, inst;
  logic        illegal, ecall, ebreak, mret;
  logic        ext_irq, tmr_irq, sw_irq;
  logic        mie;
  logic [31:0] mepc, rdata;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        hold, jump;
  logic [31:0] jump_addr;

  // Environment CSR file, written by the DUT or preloaded by the bench
  logic [31:0] csr_mstatus, csr_mepc, csr_mcause, csr_mtval, csr_mtvec;
  logic        load;
  logic [31:0] load_mstatus, load_mepc, load_mcause, load_mtval;

  // Reference state
  logic [31:0] r_mstatus, r_mepc, r_mcause, r_mtval;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .inst_valid_i     (inst_valid),
    .inst_addr_i      (inst_addr),
    .inst_i           (inst),
    .illegal_i        (illegal),
    .ecall_i          (ecall),
    .ebreak_i         (ebreak),
    .mret_i           (mret),
    .ex_trap_valid_i  (ext_irq),
    .tcmp_trap_valid_i(tmr_irq),
    .soft_trap_valid_i(sw_irq),
    .mstatus_mie_i    (mie),
    .mepc_i           (mepc),
    .trap_csr_rdata_i (rdata),
    .trap_csr_we_o    (csr_we),
    .trap_csr_addr_o  (csr_addr),
    .trap_csr_wdata_o (csr_wdata),
    .hold_o           (hold),
    .jump_o           (jump),
    .jump_addr_o      (jump_addr)
  );

  always @(posedge clk) begin
    if (load) begin
      csr_mstatus <= load_mstatus;
      csr_mepc    <= load_mepc;
      csr_mcause  <= load_mcause;
      csr_mtval   <= load_mtval;
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: csr_mstatus <= csr_wdata;
        12'h341: csr_mepc    <= csr_wdata;
        12'h342: csr_mcause  <= csr_wdata;
        12'h343: csr_mtval   <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign mepc = csr_mepc;
  assign mie  = csr_mstatus[3];

  always_comb begin
    rdata = 32'h0;
    case (csr_addr)
      12'h300: rdata = csr_mstatus;
      12'h305: rdata = csr_mtvec;
      12'h341: rdata = csr_mepc;
      default: rdata = 32'h0;
    endcase
  end

  task automatic idle_inputs();
    inst_valid = 1'b0; inst_addr = 32'h0; inst = 32'h0;
    illegal = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    ext_irq = 1'b0; tmr_irq = 1'b0; sw_irq = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] iw,
                       input logic il, input logic ec, input logic eb, input logic mr,
                       input logic ex, input logic tm, input logic sw);
    inst_valid = v; inst_addr = pc; inst = iw;
    illegal = il; ecall = ec; ebreak = eb; mret = mr;
    ext_irq = ex; tmr_irq = tm; sw_irq = sw;
  endtask

  task automatic scramble_inputs();
    drive($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Check one cycle's outputs mid-cycle, then advance to just after the next edge.
  task automatic expect_cyc(input string tag, input logic we, input logic [11:0] a,
                            input logic [31:0] wd, input logic h, input logic j,
                            input logic [31:0] ja);
    logic [78:0] obs, exp;
    @(negedge clk);
    obs = {csr_we, csr_addr, csr_wdata, hold, jump, jump_addr};
    exp = {we, a, wd, h, j, ja};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed we/addr/wdata/hold/jump/jaddr=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_csrs(input logic [31:0] ms, input logic [31:0] ep,
                           input logic [31:0] mc, input logic [31:0] mt);
    load_mstatus = ms; load_mepc = ep; load_mcause = mc; load_mtval = mt;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    r_mstatus = ms; r_mepc = ep; r_mcause = mc; r_mtval = mt;
  endtask

  task automatic check_csrs(input string tag);
    compared++;
    assert ({csr_mstatus, csr_mepc, csr_mcause, csr_mtval} === {r_mstatus, r_mepc, r_mcause, r_mtval})
    else begin
      mismatched++;
      $error("FAIL %s: observed mstatus/mepc/mcause/mtval=%h %h %h %h expected=%h %h %h %h", tag,
             csr_mstatus, csr_mepc, csr_mcause, csr_mtval, r_mstatus, r_mepc, r_mcause, r_mtval);
    end
  endtask

  // Predict and check a whole transaction starting from the currently driven request.
  task automatic run_txn(input string tag, input bit scramble);
    int          kind;
    logic [31:0] cause, tval, pc, ms_new;
    kind = 0; cause = 32'h0; tval = 32'h0; pc = inst_addr;
    if (inst_valid) begin
      if (illegal)      begin kind = 1; cause = 32'd2; tval = inst; end
      else if (ecall)   begin kind = 1; cause = 32'd11; end
      else if (ebreak)  begin kind = 1; cause = 32'd3; end
      else if (mret)    kind = 2;
      else if (r_mstatus[3]) begin
        if (ext_irq)      begin kind = 1; cause = 32'h8000_000B; end
        else if (sw_irq)  begin kind = 1; cause = 32'h8000_0003; end
        else if (tmr_irq) begin kind = 1; cause = 32'h8000_0007; end
      end
    end
    if (kind == 0) begin
      expect_cyc({tag, "_none"}, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle_inputs();
      return;
    end
    expect_cyc({tag, "_accept"}, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    if (scramble) scramble_inputs(); else idle_inputs();
    if (kind == 1) begin
      expect_cyc({tag, "_mepc"}, 1'b1, 12'h341, pc, 1'b1, 1'b0, 32'h0);
      if (scramble) scramble_inputs();
      expect_cyc({tag, "_mcause"}, 1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0);
      expect_cyc({tag, "_mtval"}, 1'b1, 12'h343, tval, 1'b1, 1'b0, 32'h0);
      ms_new = (r_mstatus & ~32'h88) | (r_mstatus[3] ? 32'h80 : 32'h0);
      expect_cyc({tag, "_mstatus"}, 1'b1, 12'h300, ms_new, 1'b1, 1'b0, 32'h0);
      expect_cyc({tag, "_jump"}, 1'b0, 12'h305, 32'h0, 1'b1, 1'b1, csr_mtvec & ~32'h3);
      r_mepc = pc; r_mcause = cause; r_mtval = tval; r_mstatus = ms_new;
    end else begin
      ms_new = (r_mstatus & ~32'h08) | 32'h80 | (r_mstatus[7] ? 32'h08 : 32'h0);
      expect_cyc({tag, "_mret_wr"}, 1'b1, 12'h300, ms_new, 1'b1, 1'b0, 32'h0);
      expect_cyc({tag, "_mret_jump"}, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, r_mepc);
      r_mstatus = ms_new;
    end
    idle_inputs();
  endtask

  initial begin
    load = 1'b0;
    load_mstatus = 32'h0; load_mepc = 32'h0; load_mcause = 32'h0; load_mtval = 32'h0;
    csr_mtvec = 32'h0000_2001;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    // Reset holds every output low even with a request present
    drive(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cyc("reset_gated", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle_inputs();
    expect_cyc("reset_quiet", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    load_csrs(32'h1888, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) expect_cyc("quiet", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Illegal instruction
    drive(1'b1, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("illegal", 1'b0);
    check_csrs("illegal_ctx");

    // External + timer with MIE set, then the same with MIE clear
    load_csrs(32'h1888, r_mepc, r_mcause, r_mtval);
    drive(1'b1, 32'h200, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_txn("ext_irq", 1'b0);
    check_csrs("ext_irq_ctx");
    drive(1'b1, 32'h200, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_txn("irq_masked", 1'b0);

    // mret restoring MIE from MPIE
    load_csrs(32'h1880, 32'h104, r_mcause, r_mtval);
    drive(1'b1, 32'h300, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("mret", 1'b0);
    check_csrs("mret_ctx");

    // ecall beats soft interrupt; the soft request is taken after mret
    load_csrs(32'h1888, r_mepc, r_mcause, r_mtval);
    drive(1'b1, 32'h400, 32'h73, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn("ecall_vs_soft", 1'b0);
    check_csrs("ecall_ctx");
    drive(1'b1, 32'h404, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_txn("mret_after_ecall", 1'b0);
    drive(1'b1, 32'h400, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn("soft_irq", 1'b0);
    check_csrs("soft_ctx");

    // Reset during the mcause write leaves a partial context
    load_csrs(32'h1888, r_mepc, r_mcause, r_mtval);
    drive(1'b1, 32'h500, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cyc("rst_mid_accept", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    expect_cyc("rst_mid_mepc", 1'b1, 12'h341, 32'h500, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    expect_cyc("rst_mid_in_reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    expect_cyc("rst_mid_after", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    r_mepc = 32'h500;
    check_csrs("rst_mid_ctx");

    // Randomized transactions with inputs scrambled mid-sequence
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0)
        load_csrs($urandom, $urandom & ~32'h3, r_mcause, r_mtval);
      if ($urandom_range(0, 7) == 0) csr_mtvec = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom & ~32'h3, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0);
      run_txn("rand", 1'b1);
    end
    check_csrs("rand_ctx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting beside the CSR register file.
- Consumes the CSR block's masked interrupt requests (external, timer, software), its global enable and its mepc value, plus exception/mret flags from the ID/EX stage.
- Drives the CSR trap write/read channel to save context (mepc, mcause, mtval, mstatus) and restore it on mret.
- Stalls the pipeline while sequencing, then issues a one-cycle PC redirect.

Parameters:
- XLEN, 32, data/address width.
- CSR_MSTATUS, 12'h300, mstatus address.
- CSR_MTVEC, 12'h305, mtvec address.
- CSR_MEPC, 12'h341, mepc address.
- CSR_MCAUSE, 12'h342, mcause address.
- CSR_MTVAL, 12'h343, mtval address.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock (clk), reset rst is synchronous and active-high.
- inst_valid_i  in  1  ID/EX holds a valid instruction.
- inst_addr_i  in  XLEN  PC of the ID/EX instruction.
- inst_i  in  32  ID/EX instruction word.
- illegal_i  in  1  illegal-instruction exception.
- ecall_i  in  1  ecall.
- ebreak_i  in  1  ebreak.
- mret_i  in  1  mret.
- ex_trap_valid_i  in  1  masked external interrupt request.
- tcmp_trap_valid_i  in  1  masked timer interrupt request.
- soft_trap_valid_i  in  1  masked software interrupt request.
- mstatus_mie_i  in  1  global interrupt enable.
- mepc_i  in  XLEN  current mepc.
- trap_csr_rdata_i  in  XLEN  CSR trap-channel read data (combinational).
- trap_csr_we_o  out  1  CSR trap-channel write enable.
- trap_csr_addr_o  out  12  CSR trap-channel address.
- trap_csr_wdata_o  out  XLEN  CSR trap-channel write data.
- hold_o  out  1  pipeline stall request.
- jump_o  out  1  one-cycle PC redirect strobe.
- jump_addr_o  out  XLEN  redirect target.

Behaviour:
- States: IDLE, S_MEPC, S_MCAUSE, S_MTVAL, S_MSTATUS, S_JUMP, S_MRET, S_MRET_JUMP.
- Reset: state = IDLE; captured cause/epc/tval registers = 0. All outputs are 0 in IDLE with no request, including during reset.
- Request evaluation in IDLE, only when inst_valid_i = 1. Priority order:
  - illegal_i (cause 2, tval = inst_i)
  - ecall_i (cause 11)
  - ebreak_i (cause 3)
  - mret_i
  - interrupts, only if mstatus_mie_i = 1: external (0x8000000B), software (0x80000003), timer (0x80000007)
- Non-illegal causes capture tval = 0.
- Accept cycle: hold_o rises combinationally in the same cycle. epc, cause and tval are registered.
  - Exception or interrupt → S_MEPC.
  - mret → S_MRET.
- Exceptions outrank a simultaneous interrupt; the interrupt remains pending and is re-evaluated after return.
- In all non-IDLE states, hold_o = 1. ID/EX must issue no CSR write while hold_o is high (CSR gives ID/EX writes priority).
- S_MEPC: we = 1, addr = MEPC, wdata = epc (faulting/interrupted PC).
- S_MCAUSE: we = 1, addr = MCAUSE, wdata = cause.
- S_MTVAL: we = 1, addr = MTVAL, wdata = tval.
- S_MSTATUS: addr = MSTATUS, we = 1, wdata = rdata with bit7 = rdata[3] (MPIE ← MIE) and bit3 = 0 (MIE ← 0); other bits pass through.
- S_JUMP: we = 0, addr = MTVEC, jump_o = 1, jump_addr_o = {rdata[31:2], 2'b00}, hold_o = 1. Next state IDLE.
- S_MRET: addr = MSTATUS, we = 1, wdata = rdata with bit3 = rdata[7] and bit7 = 1.
- S_MRET_JUMP: jump_o = 1, jump_addr_o = mepc_i (reads the value as of this cycle), next state IDLE.
- Latency:
  - Trap: accept at cycle T; writes at T+1..T+4; redirect at T+5.
  - mret: accept at T; write at T+1; redirect at T+2.
- IDLE always follows a jump, with no back-to-back acceptance in the jump cycle. The first possible new acceptance is the cycle after the jump.
- Request inputs are ignored while not in IDLE; inputs changing mid-sequence have no effect.
- rst asserted mid-sequence: next cycle state = IDLE, all outputs 0. A partially written CSR context is left as is.
- trap_csr_addr_o = 0 and trap_csr_wdata_o = 0 whenever not used.

Test Plan:
- Reset, then quiet inputs for 10 cycles → all outputs 0, state IDLE.
- Illegal at inst_addr 0x0000_0100, inst 0xFFFF_FFFF, mtvec = 0x0000_2001, mstatus = 0x1888 → writes in order mepc = 0x100, mcause = 2, mtval = 0xFFFF_FFFF, mstatus = 0x1880; jump_o at T+5 to 0x2000; hold_o high for T..T+5.
- External + timer asserted, MIE = 1, PC 0x200 → mcause = 0x8000000B, mtval = 0, jump at T+5. Same stimulus with MIE = 0 → no hold, no writes.
- mret with mstatus = 0x1880, mepc = 0x104 → mstatus write 0x1888 at T+1, jump to 0x104 at T+2.
- ecall and soft interrupt in the same cycle → mcause = 11. After the later mret restores MIE, the soft request is taken with mcause = 0x80000003.
- rst asserted during S_MCAUSE → next cycle IDLE, we/hold/jump = 0. The mcause write does not occur.
